dmem_responder: RTL and testbench

Data-memory responder for the RV32I pipeline MEM stage. Accepts one load or store request at a time over a valid/ready handshake and decodes the RISC-V funct3 width/sign encoding into byte-lane writes and sign/zero-extended reads on an internal word-organised synchronous RAM. Returns every request, load or store, as a registered response with an error flag. The MEM stage stalls on `req_ready`/`rsp_valid`.

---
 rtl/dmem_responder.sv | 150 +++++++++++++++
 tb/tb_dmem_responder.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// RV32I MEM-stage data-memory responder: single outstanding load/store over valid/ready,
// byte-lane stores and sign/zero-extended loads on a word-organised synchronous RAM.
module dmem_responder #(
    parameter int DATA_WIDTH          = 32,
    parameter int DATA_MEM_DEPTH      = 1024,
    parameter int DATA_MEM_ADDR_WIDTH = $clog2(DATA_MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RESP
    } state_t;

    state_t state;

    logic [DATA_WIDTH-1:0] mem [DATA_MEM_DEPTH];
    logic [DATA_WIDTH-1:0] rd_word;

    logic [2:0] cap_funct3;
    logic [1:0] cap_off;

    logic                           accept;
    logic                           f3_illegal;
    logic                           misaligned;
    logic                           out_of_range;
    logic                           req_err;
    logic                           mem_we;
    logic                           mem_re;
    logic [DATA_MEM_ADDR_WIDTH-1:0] word_idx;
    logic [3:0]                     byte_en;
    logic [DATA_WIDTH-1:0]          wr_data;
    logic [DATA_WIDTH-1:0]          shifted;
    logic [DATA_WIDTH-1:0]          load_ext;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign word_idx  = req_addr[DATA_MEM_ADDR_WIDTH+1:2];

    // funct3[1:0] encodes access size for both loads and stores; bit 2 selects unsigned loads.
    always_comb begin
        f3_illegal   = req_we ? (req_funct3 > 3'b010)
                              : ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11));
        misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        out_of_range = |req_addr[31:DATA_MEM_ADDR_WIDTH+2];
        req_err      = f3_illegal || misaligned || out_of_range;
        mem_we       = accept && req_we && !req_err;
        mem_re       = accept && !req_we && !req_err;
    end

    always_comb begin
        byte_en = 4'b1111;
        wr_data = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                byte_en = 4'b0001 << req_addr[1:0];
                wr_data = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                byte_en = req_addr[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{req_wdata[15:0]}};
            end
            default: begin
                byte_en = 4'b1111;
                wr_data = req_wdata;
            end
        endcase
    end

    // RAM has no reset; the write lands in the accept cycle so a later read sees it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
        if (mem_re) begin
            rd_word <= mem[word_idx];
        end
    end

    always_comb begin
        shifted  = rd_word >> {cap_off, 3'b000};
        load_ext = shifted;
        case (cap_funct3)
            3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  load_ext = {24'd0, shifted[7:0]};
            3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  load_ext = {16'd0, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            cap_funct3 <= '0;
            cap_off    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cap_funct3 <= req_funct3;
                        cap_off    <= req_addr[1:0];
                        rsp_rdata  <= '0;
                        rsp_err    <= req_err;
                        if (req_err || req_we) begin
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end else begin
                            state <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    rsp_rdata <= load_ext;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder: stores, extended loads, error
// rejection, response back-pressure and asynchronous reset during a load.
module tb_dmem_responder;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    dmem_responder #(
        .DATA_WIDTH(32),
        .DATA_MEM_DEPTH(1024)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we(req_we),
        .req_funct3(req_funct3),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One full request/response with rsp_ready high; load responses arrive one cycle later.
    task automatic applyStimulus(input string tag, input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] exp_rdata, input logic exp_err);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        checkOutput({tag, " req_ready"}, {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (!we && !exp_err) begin
            checkOutput({tag, " rd_wait valid"}, {31'd0, rsp_valid}, 32'd0);
            @(posedge clk);
            #1;
        end
        checkOutput({tag, " rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
        checkOutput({tag, " rsp_rdata"}, rsp_rdata, exp_rdata);
        checkOutput({tag, " rsp_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
        checkOutput({tag, " busy"}, {31'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput({tag, " drop valid"}, {31'd0, rsp_valid}, 32'd0);
        checkOutput({tag, " idle"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        rsp_ready  = 1'b1;

        #2;
        checkOutput("reset req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("reset rsp_rdata", rsp_rdata, 32'd0);
        checkOutput("reset rsp_err", {31'd0, rsp_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus("SW 10", 1'b1, F_W, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        applyStimulus("LW 10", 1'b0, F_W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        applyStimulus("SB 13", 1'b1, F_B, 32'h13, 32'h00000080, 32'h0, 1'b0);
        applyStimulus("LW 10b", 1'b0, F_W, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0);
        applyStimulus("LB 13", 1'b0, F_B, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0);
        applyStimulus("LBU 13", 1'b0, F_BU, 32'h13, 32'h0, 32'h00000080, 1'b0);
        applyStimulus("LB 10", 1'b0, F_B, 32'h10, 32'h0, 32'hFFFFFFEF, 1'b0);

        applyStimulus("SH 22", 1'b1, F_H, 32'h22, 32'h00001234, 32'h0, 1'b0);
        applyStimulus("LH 22", 1'b0, F_H, 32'h22, 32'h0, 32'h00001234, 1'b0);
        applyStimulus("SH 20", 1'b1, F_H, 32'h20, 32'h00008001, 32'h0, 1'b0);
        applyStimulus("LHU 20", 1'b0, F_HU, 32'h20, 32'h0, 32'h00008001, 1'b0);
        applyStimulus("LH 20", 1'b0, F_H, 32'h20, 32'h0, 32'hFFFF8001, 1'b0);
        applyStimulus("LW 20", 1'b0, F_W, 32'h20, 32'h0, 32'h12348001, 1'b0);

        applyStimulus("err LW 02", 1'b0, F_W, 32'h02, 32'h0, 32'h0, 1'b1);
        applyStimulus("err SH 11", 1'b1, F_H, 32'h11, 32'hFFFF, 32'h0, 1'b1);
        applyStimulus("err ld f3=011", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1);
        applyStimulus("err LW 1000", 1'b0, F_W, 32'h1000, 32'h0, 32'h0, 1'b1);
        applyStimulus("err SW 12", 1'b1, F_W, 32'h12, 32'h11111111, 32'h0, 1'b1);
        applyStimulus("err st f3=100", 1'b1, 3'b100, 32'h10, 32'h22222222, 32'h0, 1'b1);
        applyStimulus("err SW 1010", 1'b1, F_W, 32'h1010, 32'h33333333, 32'h0, 1'b1);
        applyStimulus("LW 10 after rej", 1'b0, F_W, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0);

        // Back-pressure: the load response must sit unchanged while rsp_ready is low.
        @(negedge clk);
        rsp_ready  = 1'b0;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = F_W;
        req_addr   = 32'h20;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            checkOutput("hold rsp_valid", {31'd0, rsp_valid}, 32'd1);
            checkOutput("hold rsp_rdata", rsp_rdata, 32'h12348001);
            checkOutput("hold req_ready", {31'd0, req_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("release req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("release rsp_valid", {31'd0, rsp_valid}, 32'd0);

        // Reset while the load sits in RD_WAIT; outputs must clear without a clock edge.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = F_W;
        req_addr   = 32'h10;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checkOutput("rst pre req_ready", {31'd0, req_ready}, 32'd0);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("rst async rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("rst async req_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst no stale valid 1", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("rst no stale valid 2", {31'd0, rsp_valid}, 32'd0);
        checkOutput("rst no stale rdata", rsp_rdata, 32'd0);

        applyStimulus("LW 10 post rst", 1'b0, F_W, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
